bmp_master_rx: RTL and testbench

BMP_MASTER_RX -- requirements
Module: bmp_master_rx

---
 rtl/bmp_pkg.sv | 29 ++
 rtl/bmp_hdr_parse.sv | 37 +++
 rtl/bmp_master_rx.sv | 150 +++++++++++++++
 tb/tb_bmp_master_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_pkg.sv
// Shared constants, FSM state and error encodings for the BMP stream receiver.
package bmp_pkg;

    localparam int HDR_BYTES      = 56;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_PIXELS,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [1:0] ERR_NONE       = 2'b00;
    localparam logic [1:0] ERR_BAD_SIZE   = 2'b01;
    localparam logic [1:0] ERR_SRC_SWITCH = 2'b10;
    localparam logic [1:0] ERR_TRUNCATED  = 2'b11;

    // A file must hold at least its header and must fit in the word-addressed buffer.
    function automatic logic size_out_of_range(input logic [31:0] fs,
                                               input int          hdr_bytes,
                                               input int          addr_w);
        logic [32:0] max_bytes;
        max_bytes = 33'(BYTES_PER_WORD) << addr_w;
        return (fs < 32'(hdr_bytes)) || ({1'b0, fs} > max_bytes);
    endfunction

endpackage

// File: rtl/bmp_hdr_parse.sv
// Captures the BMP size field, which straddles header words 0 and 1, and flags
// sizes the buffer cannot hold.
module bmp_hdr_parse #(
    parameter int ADDR_W    = 14,
    parameter int HDR_BYTES = 56
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cap_w0,
    input  logic        cap_w1,
    input  logic [15:0] w0_lo,
    input  logic [15:0] w1_hi,
    output logic [31:0] file_size,
    output logic        size_bad
);
    import bmp_pkg::*;

    logic [15:0] w0_q;
    logic [31:0] fs_new;

    assign fs_new   = {w0_q, w1_hi};
    assign size_bad = cap_w1 && size_out_of_range(fs_new, HDR_BYTES, ADDR_W);

    // A new image's first word also forgets the previous image's size.
    always_ff @(posedge clk) begin
        if (!reset) begin
            w0_q      <= '0;
            file_size <= '0;
        end else if (cap_w0) begin
            w0_q      <= w0_lo;
            file_size <= '0;
        end else if (cap_w1) begin
            file_size <= fs_new;
        end
    end

endmodule

// File: rtl/bmp_master_rx.sv
// BMP image stream receiver: writes each accepted word straight into the image
// buffer and tracks header/pixel phases. Optional pixel checksum: BMP_RX_CHECKSUM_EN.
module bmp_master_rx #(
    parameter int DATA_BUS_SIZE = 32,
    parameter int ADDR_W        = 14,
    parameter int HDR_BYTES     = bmp_pkg::HDR_BYTES
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_BUS_SIZE-1:0] mstr_data,
    input  logic [1:0]               mstr_data_valid,
    input  logic                     mstr_cmplt,
    output logic                     mstr_ready,
    input  logic                     sink_en,
    output logic                     mem_wr_en,
    output logic [ADDR_W-1:0]        mem_wr_addr,
    output logic [DATA_BUS_SIZE-1:0] mem_wr_data,
    output logic [31:0]              file_size,
    output logic                     src_id,
    output logic [31:0]              byte_count,
    output logic                     rx_busy,
    output logic                     rx_done,
    output logic                     rx_err,
    output logic [1:0]               err_code
`ifdef BMP_RX_CHECKSUM_EN
    ,
    output logic [31:0]              pix_sum
`endif
);
    import bmp_pkg::*;

    state_e            state_q, state_d;
    logic [1:0]        err_d;
    logic [ADDR_W-1:0] widx_q;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       bc_after;

    logic can_take, accept, first_beat, in_img;
    logic src_bad, wr, hdr_wr;
    logic cap_w1, size_bad, size_err;
    logic hdr_end, fin;

    assign can_take   = sink_en && (state_q == S_IDLE || state_q == S_HEADER ||
                                    state_q == S_PIXELS);
    assign accept     = mstr_data_valid[0] && can_take;
    assign first_beat = accept && (state_q == S_IDLE);
    assign in_img     = (state_q == S_HEADER) || (state_q == S_PIXELS);

    // A beat from a different slave aborts the image and is never written.
    assign src_bad = accept && in_img && (mstr_data_valid[1] != src_id);
    assign wr      = accept && !src_bad;
    assign wr_addr = first_beat ? '0 : widx_q;
    assign bc_after = first_beat ? 32'(BYTES_PER_WORD)
                                 : byte_count + 32'(BYTES_PER_WORD);

    assign hdr_wr   = wr && (state_q == S_IDLE || state_q == S_HEADER);
    assign cap_w1   = hdr_wr && (state_q == S_HEADER) && (widx_q == ADDR_W'(1));
    assign size_err = cap_w1 && size_bad;

    // A header-sized file completes on its last header word; otherwise the
    // image ends in the pixel phase once the declared size is covered.
    assign hdr_end = wr && (state_q == S_HEADER) && (bc_after == 32'(HDR_BYTES));
    assign fin     = wr && in_img && (bc_after >= file_size) &&
                     ((state_q == S_PIXELS) || hdr_end);

    bmp_hdr_parse #(
        .ADDR_W    (ADDR_W),
        .HDR_BYTES (HDR_BYTES)
    ) u_hdr (
        .clk       (clk),
        .reset     (reset),
        .cap_w0    (first_beat),
        .cap_w1    (cap_w1),
        .w0_lo     (mstr_data[15:0]),
        .w1_hi     (mstr_data[31:16]),
        .file_size (file_size),
        .size_bad  (size_bad)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            err_code   <= ERR_NONE;
            byte_count <= '0;
            widx_q     <= '0;
            src_id     <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_code <= err_d;
            if (wr) begin
                byte_count <= bc_after;
                widx_q     <= wr_addr + ADDR_W'(1);
            end
            if (first_beat)
                src_id <= mstr_data_valid[1];
        end
    end

    always_comb begin
        state_d = state_q;
        err_d   = err_code;
        case (state_q)
            S_IDLE: begin
                if (first_beat) begin
                    state_d = S_HEADER;
                    err_d   = ERR_NONE;
                end
            end
            S_HEADER, S_PIXELS: begin
                if (src_bad) begin
                    state_d = S_ERROR;
                    err_d   = ERR_SRC_SWITCH;
                end else if (size_err) begin
                    state_d = S_ERROR;
                    err_d   = ERR_BAD_SIZE;
                end else if (fin) begin
                    state_d = S_DONE;
                end else if (hdr_end) begin
                    state_d = S_PIXELS;
                end else if (mstr_cmplt) begin
                    state_d = S_ERROR;
                    err_d   = ERR_TRUNCATED;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: if (mstr_cmplt) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mstr_ready  = can_take;
        mem_wr_en   = wr;
        mem_wr_addr = wr_addr;
        mem_wr_data = mstr_data;
        rx_busy     = in_img;
        rx_done     = (state_q == S_DONE);
        rx_err      = (state_q == S_ERROR);
    end

`ifdef BMP_RX_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!reset || first_beat)
            pix_sum <= '0;
        else if (wr && state_q == S_PIXELS)
            pix_sum <= pix_sum + mstr_data;
    end
`endif

endmodule

// File: tb/tb_bmp_master_rx.sv
// Directed bench for bmp_master_rx: an image-level reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_bmp_master_rx;

    localparam int ADDR_W = 14;
    localparam int HDR    = 56;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mstr_data = '0;
    logic [1:0]  mstr_data_valid = '0;
    logic        mstr_cmplt = 1'b0;
    logic        sink_en = 1'b1;
    logic        mstr_ready, mem_wr_en, src_id, rx_busy, rx_done, rx_err;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0] mem_wr_data, file_size, byte_count;
    logic [1:0]  err_code;
`ifdef BMP_RX_CHECKSUM_EN
    logic [31:0] pix_sum;
`endif

    always #5 clk = ~clk;

    bmp_master_rx #(.DATA_BUS_SIZE(32), .ADDR_W(ADDR_W), .HDR_BYTES(HDR)) dut (
        .clk             (clk),
        .reset           (reset),
        .mstr_data       (mstr_data),
        .mstr_data_valid (mstr_data_valid),
        .mstr_cmplt      (mstr_cmplt),
        .mstr_ready      (mstr_ready),
        .sink_en         (sink_en),
        .mem_wr_en       (mem_wr_en),
        .mem_wr_addr     (mem_wr_addr),
        .mem_wr_data     (mem_wr_data),
        .file_size       (file_size),
        .src_id          (src_id),
        .byte_count      (byte_count),
        .rx_busy         (rx_busy),
        .rx_done         (rx_done),
        .rx_err          (rx_err),
        .err_code        (err_code)
`ifdef BMP_RX_CHECKSUM_EN
        ,
        .pix_sum         (pix_sum)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: the image as a byte stream with a receiving / done / error condition.
    bit          chk_en = 0;
    bit          m_recv, m_done, m_err, m_src;
    logic [1:0]  m_code;
    logic [31:0] m_bc, m_fs, m_hdr0, m_sum;
    int          wr_cnt = 0;

    always @(posedge clk) begin : model
        logic        acc;
        logic [31:0] off;
        if (reset && mem_wr_en) wr_cnt++;
        if (!reset) begin
            m_recv = 0; m_done = 0; m_err = 0; m_src = 0; m_code = 0;
            m_bc = 0; m_fs = 0; m_hdr0 = 0; m_sum = 0;
        end else begin
            acc = mstr_data_valid[0] && sink_en && !m_done && !m_err;
            if (m_done) begin
                m_done = 0;
            end else if (m_err) begin
                if (mstr_cmplt) m_err = 0;
            end else if (!m_recv) begin
                if (acc) begin
                    m_recv = 1; m_bc = 4; m_fs = 0; m_code = 0; m_sum = 0;
                    m_src = mstr_data_valid[1]; m_hdr0 = mstr_data;
                end
            end else if (acc && mstr_data_valid[1] != m_src) begin
                m_recv = 0; m_err = 1; m_code = 2'b10;
            end else begin
                if (acc) begin
                    off  = m_bc;
                    m_bc = m_bc + 4;
                    if (off >= 32'(HDR)) m_sum = m_sum + mstr_data;
                    if (off == 32'd4) begin
                        m_fs = {m_hdr0[15:0], mstr_data[31:16]};
                        if (m_fs < 32'(HDR) || m_fs > (32'd4 << ADDR_W)) begin
                            m_recv = 0; m_err = 1; m_code = 2'b01;
                        end
                    end
                end
                if (m_recv) begin
                    if (acc && m_bc >= 32'(HDR) && m_bc >= m_fs) begin
                        m_recv = 0; m_done = 1;
                    end else if (mstr_cmplt) begin
                        m_recv = 0; m_err = 1; m_code = 2'b11;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic e_ready, e_acc, e_wr;
        if (chk_en) begin
            e_ready = sink_en && !m_done && !m_err;
            e_acc   = mstr_data_valid[0] && e_ready;
            e_wr    = e_acc && !(m_recv && mstr_data_valid[1] != m_src);
            check("mstr_ready", 32'(mstr_ready), 32'(e_ready));
            check("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
            if (e_wr) begin
                check("mem_wr_addr", 32'(mem_wr_addr), m_recv ? (m_bc >> 2) : 32'd0);
                check("mem_wr_data", mem_wr_data, mstr_data);
            end
            check("rx_busy", 32'(rx_busy), 32'(m_recv));
            check("rx_done", 32'(rx_done), 32'(m_done));
            check("rx_err", 32'(rx_err), 32'(m_err));
            check("err_code", 32'(err_code), 32'(m_code));
            check("byte_count", byte_count, m_bc);
            check("file_size", file_size, m_fs);
            check("src_id", 32'(src_id), 32'(m_src));
`ifdef BMP_RX_CHECKSUM_EN
            if (m_done) check("pix_sum", pix_sum, m_sum);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] v, input logic c);
        mstr_data = d; mstr_data_valid = v; mstr_cmplt = c;
        tick();
        mstr_data_valid = 2'b00; mstr_cmplt = 1'b0;
    endtask

    function automatic logic [31:0] img_word(input int k, input logic [31:0] fs);
        if (k == 0) return {16'h424D, fs[31:16]};
        if (k == 1) return {fs[15:0], 16'h0036};
        return 32'hC0DE_0000 | 32'(k);
    endfunction

    task automatic send(input logic [31:0] fs, input int first, input int last,
                        input logic src, input logic cmplt_last);
        for (int k = first; k <= last; k++)
            beat(img_word(k, fs), {src, 1'b1}, cmplt_last && (k == last));
    endtask

    int w0;

    initial begin
        tick(); tick();
        chk_en = 1;
        reset = 1'b1;
        tick();
        check("rst_busy", 32'(rx_busy), 32'd0);
        check("rst_bc", byte_count, 32'd0);
        check("rst_code", 32'(err_code), 32'd0);

        // 64-byte image: 16 writes, done the cycle after the last beat
        w0 = wr_cnt;
        send(32'd64, 0, 15, 1'b0, 1'b0);
        check("t1_done", 32'(rx_done), 32'd1);
        check("t1_bc", byte_count, 32'd64);
        check("t1_writes", 32'(wr_cnt - w0), 32'd16);
        check("t1_fs", file_size, 32'd64);
        tick();
        check("t1_idle_done", 32'(rx_done), 32'd0);

        // 62 bytes: partial last word still needs the 16th beat
        send(32'd62, 0, 14, 1'b0, 1'b0);
        check("t2_pending", 32'(rx_done), 32'd0);
        send(32'd62, 15, 15, 1'b0, 1'b0);
        check("t2_done", 32'(rx_done), 32'd1);
        check("t2_noerr", 32'(rx_err), 32'd0);
        tick();

        // size below header length
        send(32'd40, 0, 1, 1'b0, 1'b0);
        check("t3_err", 32'(rx_err), 32'd1);
        check("t3_code", 32'(err_code), 32'd1);
        w0 = wr_cnt;
        mstr_data_valid = 2'b01;
        tick(); tick(); tick();
        mstr_data_valid = 2'b00;
        check("t3_nowr", 32'(wr_cnt - w0), 32'd0);
        beat(32'd0, 2'b00, 1'b1);
        check("t3_exit", 32'(rx_err), 32'd0);
        check("t3_code_hold", 32'(err_code), 32'd1);

        // size one word beyond buffer, then exactly the buffer size
        send(32'd65540, 0, 1, 1'b0, 1'b0);
        check("t3b_code", 32'(err_code), 32'd1);
        beat(32'd0, 2'b00, 1'b1);
        send(32'd65536, 0, 2, 1'b0, 1'b0);
        check("t3c_busy", 32'(rx_busy), 32'd1);
        beat(32'd0, 2'b00, 1'b1);
        check("t3c_trunc", 32'(err_code), 32'd3);
        beat(32'd0, 2'b00, 1'b1);

        // source switch at beat 20
        send(32'd200, 0, 19, 1'b0, 1'b0);
        w0 = wr_cnt;
        beat(img_word(20, 32'd200), 2'b11, 1'b0);
        check("t4_nowr", 32'(wr_cnt - w0), 32'd0);
        check("t4_code", 32'(err_code), 32'd2);
        check("t4_bc", byte_count, 32'd80);
        beat(32'd0, 2'b00, 1'b1);

        // back-pressure in the pixel phase
        send(32'd120, 0, 15, 1'b0, 1'b0);
        w0 = wr_cnt;
        sink_en = 1'b0;
        mstr_data = img_word(16, 32'd120);
        mstr_data_valid = 2'b01;
        repeat (5) tick();
        check("t5_ready", 32'(mstr_ready), 32'd0);
        check("t5_bc", byte_count, 32'd64);
        check("t5_nowr", 32'(wr_cnt - w0), 32'd0);
        mstr_data_valid = 2'b00;
        sink_en = 1'b1;
        send(32'd120, 16, 29, 1'b0, 1'b0);
        check("t5_done", 32'(rx_done), 32'd1);
        check("t5_bc_end", byte_count, 32'd120);
        tick();

        // truncation at 100 of 200 bytes
        send(32'd200, 0, 24, 1'b0, 1'b0);
        check("t6_bc", byte_count, 32'd100);
        beat(32'd0, 2'b00, 1'b1);
        check("t6_code", 32'(err_code), 32'd3);
        beat(32'd0, 2'b00, 1'b1);

        // end strobe coincident with the final beat, source 1
        send(32'd64, 0, 15, 1'b1, 1'b1);
        check("t7_done", 32'(rx_done), 32'd1);
        check("t7_noerr", 32'(rx_err), 32'd0);
        check("t7_src", 32'(src_id), 32'd1);
        tick();

        // all-ones pixel words
        send(32'd64, 0, 13, 1'b0, 1'b0);
        beat(32'hFFFF_FFFF, 2'b01, 1'b0);
        beat(32'hFFFF_FFFF, 2'b01, 1'b0);
        check("t8_done", 32'(rx_done), 32'd1);
`ifdef BMP_RX_CHECKSUM_EN
        check("t8_sum", pix_sum, 32'hFFFF_FFFE);
`endif
        tick();

        // reset mid-image, then a stray end strobe in idle
        send(32'd64, 0, 4, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t9_busy", 32'(rx_busy), 32'd0);
        check("t9_bc", byte_count, 32'd0);
        tick();
        check("t9_done", 32'(rx_done), 32'd0);
        check("t9_err", 32'(rx_err), 32'd0);
        beat(32'd0, 2'b00, 1'b1);
        check("t9_idle_cmplt", 32'(rx_err), 32'd0);
        tick();

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
